// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser: running status, SysEx skipping, channel filter and a
// single-entry valid/ready output register. Define MIDI_REALTIME_EN to get a realtime strobe.
module midi_msg_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       overrun,
    output logic [7:0] drop_count,
    output logic       rt_valid,
    output logic [7:0] rt_byte
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitD1,
        StWaitD2,
        StSysex
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] run_status_q, run_status_d;
    logic [6:0] data1_q, data1_d;

    logic       is_rt;
    logic       is_chan_status;
    logic       one_data_byte;

    logic       cmpl;
    logic [6:0] cmpl_d1;
    logic [6:0] cmpl_d2;
    logic [7:0] cmpl_status;
    logic       cmpl_accept;
    logic       load;
    logic       drop;

    logic       msg_valid_q, msg_valid_d;
    logic [7:0] msg_status_q, msg_status_d;
    logic [6:0] msg_data1_q, msg_data1_d;
    logic [6:0] msg_data2_q, msg_data2_d;
    logic       overrun_q, overrun_d;
    logic [7:0] drop_count_q, drop_count_d;

    assign is_rt          = (byte_in[7:3] == 5'b11111);
    assign is_chan_status = byte_in[7] && (byte_in[7:4] != 4'hF);
    assign one_data_byte  = (run_status_q[7:4] == 4'hC) || (run_status_q[7:4] == 4'hD);

    // Byte sequencing; realtime bytes fall straight through with no effect.
    always_comb begin
        state_d      = state_q;
        run_status_d = run_status_q;
        data1_d      = data1_q;
        cmpl         = 1'b0;
        cmpl_d1      = byte_in[6:0];
        cmpl_d2      = 7'd0;

        if (byte_valid && !is_rt) begin
            if (is_chan_status) begin
                run_status_d = byte_in;
                state_d      = StWaitD1;
            end else if (byte_in[7]) begin
                run_status_d = 8'd0;
                state_d      = (byte_in == 8'hF0) ? StSysex : StIdle;
            end else begin
                unique case (state_q)
                    StWaitD1: begin
                        if (one_data_byte) begin
                            cmpl = 1'b1;
                        end else begin
                            data1_d = byte_in[6:0];
                            state_d = StWaitD2;
                        end
                    end
                    StWaitD2: begin
                        cmpl    = 1'b1;
                        cmpl_d1 = data1_q;
                        cmpl_d2 = byte_in[6:0];
                        state_d = StWaitD1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Note-On with zero velocity is presented as Note-Off on the same channel.
    always_comb begin
        cmpl_status = run_status_q;
        if ((run_status_q[7:4] == 4'h9) && (cmpl_d2 == 7'd0)) begin
            cmpl_status = {4'h8, run_status_q[3:0]};
        end
    end

    assign cmpl_accept = OMNI || (run_status_q[3:0] == CHANNEL);
    assign load        = cmpl && cmpl_accept && (!msg_valid_q || msg_ready);
    assign drop        = cmpl && cmpl_accept && msg_valid_q && !msg_ready;

    always_comb begin
        msg_valid_d  = msg_valid_q;
        msg_status_d = msg_status_q;
        msg_data1_d  = msg_data1_q;
        msg_data2_d  = msg_data2_q;
        overrun_d    = overrun_q;
        drop_count_d = drop_count_q;

        if (load) begin
            msg_valid_d  = 1'b1;
            msg_status_d = cmpl_status;
            msg_data1_d  = cmpl_d1;
            msg_data2_d  = cmpl_d2;
        end else if (msg_valid_q && msg_ready) begin
            msg_valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            run_status_q <= 8'd0;
            data1_q      <= 7'd0;
            msg_valid_q  <= 1'b0;
            msg_status_q <= 8'd0;
            msg_data1_q  <= 7'd0;
            msg_data2_q  <= 7'd0;
            overrun_q    <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            run_status_q <= run_status_d;
            data1_q      <= data1_d;
            msg_valid_q  <= msg_valid_d;
            msg_status_q <= msg_status_d;
            msg_data1_q  <= msg_data1_d;
            msg_data2_q  <= msg_data2_d;
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign msg_valid  = msg_valid_q;
    assign msg_status = msg_status_q;
    assign msg_data1  = msg_data1_q;
    assign msg_data2  = msg_data2_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_count_q;

`ifdef MIDI_REALTIME_EN
    logic       rt_valid_q;
    logic [7:0] rt_byte_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rt_valid_q <= 1'b0;
            rt_byte_q  <= 8'd0;
        end else begin
            rt_valid_q <= byte_valid && is_rt;
            if (byte_valid && is_rt) begin
                rt_byte_q <= byte_in;
            end
        end
    end

    assign rt_valid = rt_valid_q;
    assign rt_byte  = rt_byte_q;
`else
    assign rt_valid = 1'b0;
    assign rt_byte  = 8'd0;
`endif

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser: an OMNI instance and a CHANNEL=2 filtered instance
// share one byte stream; a message-level model predicts transfers, drops and overrun.
module tb_midi_msg_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       msg_ready;

    logic       a_valid, f_valid;
    logic [7:0] a_status, f_status;
    logic [6:0] a_d1, a_d2, f_d1, f_d2;
    logic       a_ovr, f_ovr;
    logic [7:0] a_drops, f_drops;
    logic       a_rtv, f_rtv;
    logic [7:0] a_rtb, f_rtb;

    midi_msg_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .msg_valid(a_valid), .msg_ready(msg_ready), .msg_status(a_status),
        .msg_data1(a_d1), .msg_data2(a_d2), .overrun(a_ovr), .drop_count(a_drops),
        .rt_valid(a_rtv), .rt_byte(a_rtb)
    );

    midi_msg_parser #(.CHANNEL(4'd2), .OMNI(1'b0)) dut_f (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .msg_valid(f_valid), .msg_ready(msg_ready), .msg_status(f_status),
        .msg_data1(f_d1), .msg_data2(f_d2), .overrun(f_ovr), .drop_count(f_drops),
        .rt_valid(f_rtv), .rt_byte(f_rtb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected transfers, packed as {status, 0, data1, 0, data2}.
    logic [23:0] q0[$];
    logic [23:0] q1[$];
    bit          full[2];
    int          drops[2];
    bit          ovr[2];

    // Message-level parser model: current running status and collected data bytes.
    bit          rs_ok;
    logic [7:0]  rs;
    logic [6:0]  pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        rs_ok = 1'b0;
        rs    = 8'd0;
        pend.delete();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            full[i]  = 1'b0;
            drops[i] = 0;
            ovr[i]   = 1'b0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit c, output logic [23:0] m);
        int         need;
        logic [7:0] st;
        logic [6:0] d1, d2;
        c = 1'b0;
        m = 24'd0;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            pend.delete();
            rs_ok = (b < 8'hF0);
            rs    = b;
        end else if (rs_ok) begin
            pend.push_back(b[6:0]);
            need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
            if (pend.size() == need) begin
                d1 = pend[0];
                d2 = (need == 2) ? pend[1] : 7'd0;
                st = rs;
                if (st[7:4] == 4'h9 && d2 == 7'd0) st[7:4] = 4'h8;
                m  = {st, 1'b0, d1, 1'b0, d2};
                c  = 1'b1;
                pend.delete();
            end
        end
    endtask

    task automatic deliver(input int idx, input bit c, input logic [23:0] m, input bit rdy);
        bit acc;
        acc = (idx == 0) || (m[19:16] == 4'd2);
        if (c && acc) begin
            if (full[idx] && !rdy) begin
                ovr[idx] = 1'b1;
                if (drops[idx] < 255) drops[idx]++;
            end else begin
                if (idx == 0) q0.push_back(m);
                else q1.push_back(m);
                full[idx] = 1'b1;
            end
        end else if (full[idx] && rdy) begin
            full[idx] = 1'b0;
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit rdy);
        bit          c;
        logic [23:0] m;
        byte_valid = v;
        byte_in    = b;
        msg_ready  = rdy;
        c = 1'b0;
        m = 24'd0;
        if (v) model_byte(b, c, m);
        deliver(0, c, m, rdy);
        deliver(1, c, m, rdy);
        @(posedge clk);
        #1;
        check("valid_omni", 32'(a_valid), 32'(full[0]));
        check("valid_filt", 32'(f_valid), 32'(full[1]));
        check("drops_omni", 32'(a_drops), 32'(drops[0]));
        check("drops_filt", 32'(f_drops), 32'(drops[1]));
        check("overrun_omni", 32'(a_ovr), 32'(ovr[0]));
        check("overrun_filt", 32'(f_ovr), 32'(ovr[1]));
`ifdef MIDI_REALTIME_EN
        check("rt_valid", 32'(a_rtv), 32'(v && b >= 8'hF8));
        if (v && b >= 8'hF8) check("rt_byte", 32'(a_rtb), 32'(b));
`else
        check("rt_valid", 32'(a_rtv | f_rtv), 32'd0);
        check("rt_byte", 32'(a_rtb | f_rtb), 32'd0);
`endif
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        cycle(1'b1, b, rdy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
    endtask

    // Monitor: every transfer seen on either instance must match the scoreboard front.
    always @(negedge clk) begin
        if (reset === 1'b1 && msg_ready === 1'b1) begin
            if (a_valid) begin
                if (q0.size() == 0) check("omni_unexpected_msg", 32'd1, 32'd0);
                else check("omni_msg", {8'd0, a_status, 1'b0, a_d1, 1'b0, a_d2},
                           {8'd0, q0.pop_front()});
            end
            if (f_valid) begin
                if (q1.size() == 0) check("filt_unexpected_msg", 32'd1, 32'd0);
                else check("filt_msg", {8'd0, f_status, 1'b0, f_d1, 1'b0, f_d2},
                           {8'd0, q1.pop_front()});
            end
        end
    end

    function automatic logic [7:0] rand_byte();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 55) return 8'($urandom_range(0, 127));
        if (r < 80) begin
            int ch;
            ch = int'($urandom_range(0, 3));
            return {4'($urandom_range(8, 14)), (ch == 0) ? 4'd2 : 4'($urandom_range(0, 15))};
        end
        if (r < 90) return 8'($urandom_range(8'hF8, 8'hFF));
        return 8'($urandom_range(8'hF0, 8'hF7));
    endfunction

    initial begin
        reset      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        msg_ready  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(a_valid | f_valid), 32'd0);
        check("reset_fields", {8'd0, a_status, a_d1, a_d2}, 32'd0);
        check("reset_drops", 32'(a_drops), 32'd0);
        reset = 1'b1;
        idle(2);

        // Note-On, shows one-cycle latency after the last data byte.
        send(8'h92, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        check("noteon_status", 32'(a_status), 32'h92);
        check("noteon_d1", 32'(a_d1), 32'h3C);
        check("noteon_d2", 32'(a_d2), 32'h64);
        idle(2);

        // Running status with velocity-0 normalisation.
        send(8'h90, 1'b1); send(8'h40, 1'b1); send(8'h7F, 1'b1);
        send(8'h41, 1'b1); send(8'h00, 1'b1);
        check("runstat_status", 32'(a_status), 32'h80);
        check("runstat_d1", 32'(a_d1), 32'h41);
        idle(2);

        // One-data-byte message with interleaved realtime.
        send(8'hC3, 1'b1); send(8'hF8, 1'b1); send(8'h05, 1'b1);
        check("prog_status", 32'(a_status), 32'hC3);
        check("prog_d2", 32'(a_d2), 32'h00);
        idle(2);

        // SysEx body and trailing data discarded; status abort of partial message.
        send(8'hF0, 1'b1); send(8'h12, 1'b1); send(8'h34, 1'b1); send(8'hF7, 1'b1);
        send(8'h45, 1'b1);
        check("sysex_none", 32'(a_valid), 32'd0);
        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'hB0, 1'b1); send(8'h07, 1'b1);
        send(8'h10, 1'b1);
        check("abort_status", 32'(a_status), 32'hB0);
        idle(2);

        // Backpressure: second message dropped, first held.
        send(8'h90, 1'b0); send(8'h3C, 1'b0); send(8'h64, 1'b0);
        send(8'h90, 1'b0); send(8'h3D, 1'b0); send(8'h64, 1'b0);
        check("bp_overrun", 32'(a_ovr), 32'd1);
        check("bp_drops", 32'(a_drops), 32'd1);
        check("bp_held_d1", 32'(a_d1), 32'h3C);
        idle(2);
        // Completion coinciding with ready: not a drop.
        send(8'h3E, 1'b0); send(8'h64, 1'b0);
        send(8'h3F, 1'b0); send(8'h64, 1'b1);
        check("sameclk_drops", 32'(a_drops), 32'd1);
        check("sameclk_d1", 32'(a_d1), 32'h3F);
        idle(2);

        // Channel filter: only channel 2 reaches the filtered instance.
        send(8'h91, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        check("filter_reject", 32'(f_valid), 32'd0);
        send(8'h92, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        check("filter_accept", 32'(f_status), 32'h92);
        idle(2);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 9) < 7), rand_byte(), ($urandom_range(0, 9) < 6));
        end
        idle(4);
        check("omni_queue_empty", 32'(q0.size()), 32'd0);
        check("filt_queue_empty", 32'(q1.size()), 32'd0);

        // Saturating drop counter.
        send(8'hC0, 1'b0);
        for (int i = 0; i < 300; i++) send(8'h05, 1'b0);
        check("drops_saturate", 32'(a_drops), 32'd255);
        idle(2);

        // Reset mid-message loses the partial message and running status.
        send(8'h92, 1'b0); send(8'h3C, 1'b0);
        reset = 1'b0;
        model_clear();
        #2;
        check("midreset_valid", 32'(a_valid | f_valid), 32'd0);
        check("midreset_drops", 32'(a_drops), 32'd0);
        check("midreset_ovr", 32'(a_ovr), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send(8'h3C, 1'b1); send(8'h64, 1'b1);
        check("postreset_none", 32'(a_valid | f_valid), 32'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
